icache_dm: RTL and testbench

//  Direct-mapped, parametrised instruction cache between the fetch stage and instruction memory.

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_tag_array.sv | 54 +++++
 rtl/icache_dm.sv | 182 ++++++++++++++++++
 tb/tb_icache_dm.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg
//   Shared definitions for the direct-mapped instruction cache:
//   the line-fill FSM state type and the default geometry.
//   Field widths (offset, line, tag) depend on the instance parameters,
//   so they are derived with $clog2 inside the modules that use them.
package icache_pkg;

  // IDLE serves lookups, FILL streams a line in from memory,
  // RESPOND hands the missed word back to fetch.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RESPOND = 2'd2
  } icacheState_e;

  localparam int DefDataW = 16;
  localparam int DefAddrW = 32;
  localparam int DefLines = 16;
  localparam int DefWords = 4;

endpackage

// File: rtl/icache_tag_array.sv
// icache_tag_array
//   Valid bit and tag storage for every cache line.
//   Ports:
//     clk, not_reset       clock, asynchronous active-low reset (clears valid bits)
//     lookup_line_i/tag_i  combinational lookup address, hit_o = valid && tag match
//     wr_en_i              write wr_tag_i into line wr_line_i
//     wr_line_i, wr_tag_i  line and tag to install
//     set_valid_i          value written into the valid bit of wr_line_i
//     flush_i              clear every valid bit (wins over a same-cycle write)
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int LINES = DefLines,
  parameter int LW    = $clog2(LINES),
  parameter int TW    = 26
) (
  input  logic          clk,
  input  logic          not_reset,
  input  logic [LW-1:0] lookup_line_i,
  input  logic [TW-1:0] lookup_tag_i,
  output logic          hit_o,
  input  logic          wr_en_i,
  input  logic [LW-1:0] wr_line_i,
  input  logic [TW-1:0] wr_tag_i,
  input  logic          set_valid_i,
  input  logic          flush_i
);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q [LINES];

  // Valid bits are the only state that must be known after reset; a flush
  // overrides an install landing on the same edge, so an invalidate that
  // coincides with the last fill beat still leaves the line invalid.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_line_i] <= set_valid_i;
    end
  end

  // Tags carry no reset: a tag is only meaningful under its valid bit.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_line_i] <= wr_tag_i;
    end
  end

  assign hit_o = valid_q[lookup_line_i] && (tag_q[lookup_line_i] == lookup_tag_i);

endmodule

// File: rtl/icache_dm.sv
// icache_dm
//   Direct-mapped instruction cache between fetch and instruction memory.
//   Hits return one word per cycle with a registered 1-cycle latency; a miss
//   runs a line fill over a req/ack memory port and then returns the word.
//   Ports:
//     clk, not_reset   clock, asynchronous active-low reset
//     not_enable       0 = fetch request on index this cycle
//     index            word address of the requested instruction
//     invalidate       1-cycle pulse clearing all valid bits
//     data, ready      returned instruction (0 unless ready) and its strobe
//     busy             high while a line fill is in progress
//     mem_req          memory read request, held until mem_ack
//     mem_addr         word address of the current fill beat
//     mem_ack          beat accepted, mem_data valid in the same cycle
//     mem_data         returned word
module icache_dm
  import icache_pkg::*;
#(
  parameter int DATA_W = DefDataW,
  parameter int ADDR_W = DefAddrW,
  parameter int LINES  = DefLines,
  parameter int WORDS  = DefWords
) (
  input  logic              clk,
  input  logic              not_reset,
  input  logic              not_enable,
  input  logic [ADDR_W-1:0] index,
  input  logic              invalidate,
  output logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int OW = $clog2(WORDS);
  localparam int LW = $clog2(LINES);
  localparam int TW = ADDR_W - OW - LW;

  localparam logic [OW-1:0] LastBeat = OW'(WORDS - 1);

  icacheState_e      state_q, state_d;
  logic [ADDR_W-1:0] reqIndex_q, reqIndex_d;
  logic [OW-1:0]     beat_q, beat_d;
  logic [DATA_W-1:0] respWord_q, respWord_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              flushSeen_q, flushSeen_d;

  logic [DATA_W-1:0] dataMem [LINES*WORDS];

  logic [OW-1:0] reqOff;
  logic [LW-1:0] reqLine;
  logic [TW-1:0] reqTag;
  logic [LW-1:0] fillLine;
  logic [TW-1:0] fillTag;
  logic          hit;
  logic          tagWrEn;
  logic          setValid;

  assign reqOff   = index[OW-1:0];
  assign reqLine  = index[OW+LW-1:OW];
  assign reqTag   = index[ADDR_W-1:OW+LW];
  assign fillLine = reqIndex_q[OW+LW-1:OW];
  assign fillTag  = reqIndex_q[ADDR_W-1:OW+LW];

  icache_tag_array #(
    .LINES (LINES),
    .LW    (LW),
    .TW    (TW)
  ) u_tags (
    .clk           (clk),
    .not_reset     (not_reset),
    .lookup_line_i (reqLine),
    .lookup_tag_i  (reqTag),
    .hit_o         (hit),
    .wr_en_i       (tagWrEn),
    .wr_line_i     (fillLine),
    .wr_tag_i      (fillTag),
    .set_valid_i   (setValid),
    .flush_i       (invalidate)
  );

  // Next-state logic. The missed word is captured as its beat streams past
  // so RESPOND need not read the array back. An invalidate seen at any point
  // of the fill is remembered and keeps the freshly filled line invalid.
  always_comb begin
    state_d     = state_q;
    reqIndex_d  = reqIndex_q;
    beat_d      = beat_q;
    respWord_d  = respWord_q;
    flushSeen_d = flushSeen_q;
    data_d      = '0;
    ready_d     = 1'b0;
    tagWrEn     = 1'b0;
    setValid    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!not_enable) begin
          if (hit) begin
            data_d  = dataMem[{reqLine, reqOff}];
            ready_d = 1'b1;
          end else begin
            reqIndex_d  = index;
            beat_d      = '0;
            flushSeen_d = 1'b0;
            state_d     = FILL;
          end
        end
      end

      FILL: begin
        if (invalidate) begin
          flushSeen_d = 1'b1;
        end
        if (mem_ack) begin
          if (beat_q == reqIndex_q[OW-1:0]) begin
            respWord_d = mem_data;
          end
          beat_d = beat_q + OW'(1);
          if (beat_q == LastBeat) begin
            tagWrEn  = 1'b1;
            setValid = !(flushSeen_q || invalidate);
            state_d  = RESPOND;
          end
        end
      end

      RESPOND: begin
        if (!not_enable) begin
          data_d  = respWord_q;
          ready_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any fill in flight.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q     <= IDLE;
      reqIndex_q  <= '0;
      beat_q      <= '0;
      respWord_q  <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      flushSeen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      reqIndex_q  <= reqIndex_d;
      beat_q      <= beat_d;
      respWord_q  <= respWord_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      flushSeen_q <= flushSeen_d;
    end
  end

  // Data store: written one word per accepted beat, never reset.
  always_ff @(posedge clk) begin
    if (state_q == FILL && mem_ack) begin
      dataMem[{fillLine, beat_q}] <= mem_data;
    end
  end

  // Request and address come straight from the state register so an
  // asynchronous reset drops mem_req immediately.
  assign busy     = (state_q == FILL);
  assign mem_req  = (state_q == FILL);
  assign mem_addr = (state_q == FILL) ? {reqIndex_q[ADDR_W-1:OW], beat_q} : '0;
  assign data     = data_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm
//   Self-checking bench for icache_dm (LINES=16, WORDS=4). Memory returns
//   0x1000+addr; a reference model tracks which lines hold which tags.
module tb_icache_dm;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 32;
  localparam int LINES  = 16;
  localparam int WORDS  = 4;

  logic              clk = 1'b0;
  logic              not_reset;
  logic              not_enable;
  logic [ADDR_W-1:0] index;
  logic              invalidate;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;

  int compared   = 0;
  int mismatched = 0;

  int ackDelay = 0;
  int waitCnt  = 0;
  logic [ADDR_W-1:0] fillLog [$];

  // Reference model: which tag each line holds and whether it is valid.
  bit          refValid [LINES];
  logic [31:0] refTag   [LINES];

  typedef struct {
    logic [31:0] idx;
    bit          expHit;
    logic [15:0] expData;
  } vec_t;

  vec_t vecs [9];

  icache_dm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LINES  (LINES),
    .WORDS  (WORDS)
  ) dut (
    .clk        (clk),
    .not_reset  (not_reset),
    .not_enable (not_enable),
    .index      (index),
    .invalidate (invalidate),
    .data       (data),
    .ready      (ready),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  // Memory model: acks a beat after ackDelay waiting cycles. ackDelay 0 keeps
  // ack high continuously so beats go back to back.
  always @(negedge clk) begin
    if (!not_reset || !mem_req) begin
      mem_ack  = 1'b0;
      mem_data = '0;
      waitCnt  = 0;
    end else if (mem_ack && ackDelay != 0) begin
      mem_ack  = 1'b0;
      mem_data = '0;
      waitCnt  = 0;
    end else if (waitCnt >= ackDelay) begin
      mem_ack  = 1'b1;
      mem_data = 16'h1000 + mem_addr[15:0];
      fillLog.push_back(mem_addr);
    end else begin
      mem_ack = 1'b0;
      waitCnt++;
    end
  end

  function automatic int lineOf(input logic [31:0] idx);
    return int'((idx / 32'(WORDS)) % 32'(LINES));
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] idx);
    return idx / 32'(WORDS * LINES);
  endfunction

  function automatic bit modelHit(input logic [31:0] idx);
    return refValid[lineOf(idx)] && (refTag[lineOf(idx)] == tagOf(idx));
  endfunction

  function automatic logic [15:0] modelWord(input logic [31:0] idx);
    logic [15:0] w;
    w = 16'h1000 + idx[15:0];
    return w;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < LINES; i++) refValid[i] = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One fetch: request held until ready, checks latency, data, fill sequence.
  task automatic applyStimulus(input logic [31:0] idx, input bit expHit,
                               input logic [15:0] expData, input bit flushMid,
                               input string name);
    int          cycles;
    bit          got;
    logic        busyFirst;
    logic [31:0] base;
    cycles    = 0;
    got       = 1'b0;
    busyFirst = 1'b0;
    base      = (idx / 32'(WORDS)) * 32'(WORDS);
    fillLog.delete();
    not_enable = 1'b0;
    index      = idx;
    invalidate = 1'b0;
    while (!got && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) busyFirst = busy;
      if (ready) got = 1'b1;
      else invalidate = flushMid && (cycles == 2);
    end
    invalidate = 1'b0;
    not_enable = 1'b1;
    checkOutput($sformatf("%s idx=%0h ready", name, idx), 32'(got), 32'd1);
    checkOutput($sformatf("%s idx=%0h data", name, idx), 32'(data), 32'(expData));
    checkOutput($sformatf("%s idx=%0h busy", name, idx), 32'(busyFirst), 32'(!expHit));
    if (expHit) begin
      checkOutput($sformatf("%s idx=%0h latency", name, idx), 32'(cycles), 32'd1);
      checkOutput($sformatf("%s idx=%0h beats", name, idx), 32'(fillLog.size()), 32'd0);
    end else begin
      checkOutput($sformatf("%s idx=%0h beats", name, idx), 32'(fillLog.size()), 32'(WORDS));
      for (int k = 0; k < WORDS; k++) begin
        if (k < fillLog.size())
          checkOutput($sformatf("%s idx=%0h beat%0d addr", name, idx, k), fillLog[k], base + 32'(k));
      end
      checkOutput($sformatf("%s idx=%0h req after", name, idx), 32'(mem_req), 32'd0);
      refTag[lineOf(idx)] = tagOf(idx);
      if (flushMid) clearModel();
      else refValid[lineOf(idx)] = 1'b1;
    end
  endtask

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  initial begin
    #1_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    printSummary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cycles;
    logic [31:0] idx;
    int          r;

    vecs[0] = '{32'd10,         1'b0, 16'h100A};
    vecs[1] = '{32'd11,         1'b1, 16'h100B};
    vecs[2] = '{32'd8,          1'b1, 16'h1008};
    vecs[3] = '{32'd74,         1'b0, 16'h104A};
    vecs[4] = '{32'd10,         1'b0, 16'h100A};
    vecs[5] = '{32'hFFFF_FFFF,  1'b0, 16'h0FFF};
    vecs[6] = '{32'hFFFF_FFFC,  1'b1, 16'h0FFC};
    vecs[7] = '{32'd63,         1'b0, 16'h103F};
    vecs[8] = '{32'hFFFF_FFFD,  1'b0, 16'h0FFD};

    not_reset  = 1'b0;
    not_enable = 1'b1;
    index      = '0;
    invalidate = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    checkOutput("reset data", 32'(data), 32'd0);
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    not_reset = 1'b1;
    @(negedge clk);

    // Table: cold miss, hits, conflict, wrap-around at the top of memory.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].expHit, vecs[i].expData, 1'b0, "vec");
    end

    // Idle cycle: index ignored, no memory activity.
    not_enable = 1'b1;
    index      = 32'd13;
    @(negedge clk);
    checkOutput("idle ready", 32'(ready), 32'd0);
    checkOutput("idle data", 32'(data), 32'd0);
    checkOutput("idle mem_req", 32'(mem_req), 32'd0);
    applyStimulus(32'd11, 1'b1, 16'h100B, 1'b0, "re-enable");

    // Invalidate with a same-cycle lookup still hits on pre-flush state.
    not_enable = 1'b0;
    index      = 32'd8;
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    not_enable = 1'b1;
    checkOutput("flush lookup ready", 32'(ready), 32'd1);
    checkOutput("flush lookup data", 32'(data), 32'h1008);
    clearModel();
    applyStimulus(32'd11, 1'b0, 16'h100B, 1'b0, "post-flush");
    applyStimulus(32'd9, 1'b1, 16'h1009, 1'b0, "post-flush");

    // Invalidate during a fill: word returned, line left invalid.
    applyStimulus(32'd74, 1'b0, 16'h104A, 1'b1, "flush-in-fill");
    applyStimulus(32'd75, 1'b0, 16'h104B, 1'b0, "after flush-in-fill");

    // Request withdrawn during fill (and index changed): no response, line installed.
    fillLog.delete();
    not_enable = 1'b0;
    index      = 32'd20;
    @(negedge clk);
    checkOutput("withdrawn busy", 32'(busy), 32'd1);
    not_enable = 1'b1;
    index      = 32'd99;
    cycles     = 0;
    while (busy && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("withdrawn fill done", 32'(busy), 32'd0);
    checkOutput("withdrawn ready respond", 32'(ready), 32'd0);
    @(negedge clk);
    checkOutput("withdrawn ready after", 32'(ready), 32'd0);
    checkOutput("withdrawn data after", 32'(data), 32'd0);
    checkOutput("withdrawn beats", 32'(fillLog.size()), 32'(WORDS));
    if (fillLog.size() == WORDS) begin
      checkOutput("withdrawn first beat", fillLog[0], 32'd20);
      checkOutput("withdrawn last beat", fillLog[WORDS-1], 32'd23);
    end
    refValid[lineOf(32'd20)] = 1'b1;
    refTag[lineOf(32'd20)]   = tagOf(32'd20);
    applyStimulus(32'd21, 1'b1, 16'h1015, 1'b0, "installed");

    // Slow memory: request and address stable while ack is held low,
    // then reset after the first beat drops the request at once.
    ackDelay = 3;
    fillLog.delete();
    not_enable = 1'b0;
    index      = 32'd10;
    cycles     = 0;
    while (cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (fillLog.size() >= 1) break;
      checkOutput("stall mem_req", 32'(mem_req), 32'd1);
      checkOutput("stall mem_addr", mem_addr, 32'd8);
    end
    checkOutput("stall first beat taken", 32'(fillLog.size()), 32'd1);
    checkOutput("stall second addr", mem_addr, 32'd9);
    not_reset = 1'b0;
    #1;
    checkOutput("abort mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort mem_addr", mem_addr, 32'd0);
    checkOutput("abort ready", 32'(ready), 32'd0);
    not_enable = 1'b1;
    @(negedge clk);
    not_reset = 1'b1;
    ackDelay  = 0;
    clearModel();
    @(negedge clk);
    applyStimulus(32'd10, 1'b0, 16'h100A, 1'b0, "post-reset");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        not_enable = 1'b1;
        index      = $urandom;
        @(negedge clk);
        checkOutput("rand idle ready", 32'(ready), 32'd0);
        checkOutput("rand idle data", 32'(data), 32'd0);
      end else if (r == 1) begin
        not_enable = 1'b1;
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        clearModel();
        checkOutput("rand flush ready", 32'(ready), 32'd0);
      end else begin
        idx = 32'($urandom_range(0, 255));
        if (r == 9) idx = 32'hFFFF_FF00 | idx;
        ackDelay = $urandom_range(0, 3);
        applyStimulus(idx, modelHit(idx), modelWord(idx),
                      $urandom_range(0, 7) == 0, "rand");
      end
    end

    printSummary();
    $finish;
  end

endmodule
